// File: rtl/grf_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : grf_wb_queue
//  Purpose  : Write-back queue in front of the GRF write port. Buffers
//             register-write requests (address, data, PC) from the W stage in
//             an in-order circular FIFO. Issues at most one GRF write per
//             cycle while drain_en_i allows it. Reports whether a queued write
//             targets either of two probe addresses, for hazard detection.
//
//  Ports    :
//    clk_i         system clock; all state changes on the rising edge
//    reset_i       synchronous active-low reset
//    in_valid_i    write request present
//    in_ready_o    queue can accept a request this cycle
//    in_addr_i     destination register number (writes to $0 are dropped)
//    in_data_i     write data
//    in_pc_i       PC of the producing instruction
//    drain_en_i    GRF write port available this cycle
//    flush_i       discard queued and concurrently offered requests
//    grf_we_o      GRF write enable
//    grf_a3_o      GRF write address
//    grf_wd_o      GRF write data
//    grf_wpc_o     PC reported with the write
//    chk_addr1_i   first probe address
//    chk_addr2_i   second probe address
//    chk_hit1_o    a queued entry targets chk_addr1_i
//    chk_hit2_o    a queued entry targets chk_addr2_i
//    count_o       number of occupied entries
//
//  Revision : 1.0 - initial release
// ============================================================================
module grf_wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [4:0]                 in_addr_i,
   input  logic [31:0]                in_data_i,
   input  logic [31:0]                in_pc_i,
   input  logic                       drain_en_i,
   input  logic                       flush_i,
   output logic                       grf_we_o,
   output logic [4:0]                 grf_a3_o,
   output logic [31:0]                grf_wd_o,
   output logic [31:0]                grf_wpc_o,
   input  logic [4:0]                 chk_addr1_i,
   input  logic [4:0]                 chk_addr2_i,
   output logic                       chk_hit1_o,
   output logic                       chk_hit2_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [AW-1:0] c_PTR_ONE = AW'(1);
   localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
   localparam logic [CW-1:0] c_CNT_MAX = CW'(DEPTH);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [4:0]    addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   pc_q   [DEPTH];

   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   // ------------------------------------------------------------------------
   // Handshake and pop decisions
   // ------------------------------------------------------------------------
   logic w_accept;
   logic w_push;
   logic w_pop;
   logic w_nonempty;

   assign w_nonempty = (count_q != '0);

   // Readiness looks only at current occupancy, never at a same-cycle pop,
   // so a full queue refuses a push even while it is draining.
   assign in_ready_o = (count_q < c_CNT_MAX) && !flush_i;
   assign w_accept   = in_valid_i && in_ready_o;

   // Writes to $0 complete the handshake but are never stored.
   assign w_push     = w_accept && (in_addr_i != 5'd0);
   assign w_pop      = w_nonempty && drain_en_i && !flush_i;

   // ------------------------------------------------------------------------
   // Next-state for pointers and occupancy
   // ------------------------------------------------------------------------
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (w_push) begin
            tail_d = tail_q + c_PTR_ONE;
         end
         if (w_pop) begin
            head_d = head_q + c_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else if (w_push) begin
         addr_q[tail_q] <= in_addr_i;
         data_q[tail_q] <= in_data_i;
         pc_q[tail_q]   <= in_pc_i;
      end
   end

   // ------------------------------------------------------------------------
   // GRF write port: head entry, forced to zero while the queue is empty
   // ------------------------------------------------------------------------
   assign grf_we_o  = w_pop;
   assign grf_a3_o  = w_nonempty ? addr_q[head_q] : 5'd0;
   assign grf_wd_o  = w_nonempty ? data_q[head_q] : 32'd0;
   assign grf_wpc_o = w_nonempty ? pc_q[head_q]   : 32'd0;
   assign count_o   = count_q;

   // ------------------------------------------------------------------------
   // Hazard probes over occupied entries only
   // ------------------------------------------------------------------------
   logic [DEPTH-1:0] w_hit1;
   logic [DEPTH-1:0] w_hit2;

   for (genvar g = 0; g < DEPTH; g++) begin : g_probe
      logic [AW-1:0] w_off;
      logic          w_occ;

      // Distance from the head, modulo DEPTH; the slot is live when that
      // distance is below the occupancy.
      assign w_off     = AW'(g) - head_q;
      assign w_occ     = ({1'b0, w_off} < count_q);
      assign w_hit1[g] = w_occ && (addr_q[g] == chk_addr1_i);
      assign w_hit2[g] = w_occ && (addr_q[g] == chk_addr2_i);
   end

   assign chk_hit1_o = (chk_addr1_i != 5'd0) && (|w_hit1);
   assign chk_hit2_o = (chk_addr2_i != 5'd0) && (|w_hit2);

endmodule
`default_nettype wire

// File: tb/tb_grf_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grf_wb_queue
//  Purpose  : Directed self-checking bench for grf_wb_queue (DEPTH = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_grf_wb_queue;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_addr;
   logic [31:0] in_data;
   logic [31:0] in_pc;
   logic        drain_en;
   logic        flush;
   logic        grf_we;
   logic [4:0]  grf_a3;
   logic [31:0] grf_wd;
   logic [31:0] grf_wpc;
   logic [4:0]  chk_addr1;
   logic [4:0]  chk_addr2;
   logic        chk_hit1;
   logic        chk_hit2;
   logic [2:0]  count;

   int n_checks;
   int n_fails;

   grf_wb_queue #(.DEPTH(4)) u_dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_addr_i   (in_addr),
      .in_data_i   (in_data),
      .in_pc_i     (in_pc),
      .drain_en_i  (drain_en),
      .flush_i     (flush),
      .grf_we_o    (grf_we),
      .grf_a3_o    (grf_a3),
      .grf_wd_o    (grf_wd),
      .grf_wpc_o   (grf_wpc),
      .chk_addr1_i (chk_addr1),
      .chk_addr2_i (chk_addr2),
      .chk_hit1_o  (chk_hit1),
      .chk_hit2_o  (chk_hit2),
      .count_o     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are changed just after it and
   // outputs are sampled at the following falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic offer(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
      in_valid = v;
      in_addr  = a;
      in_data  = d;
      in_pc    = p;
   endtask

   logic [4:0] exp_addr [9];

   initial begin
      n_checks  = 0;
      n_fails   = 0;
      reset     = 1'b0;
      drain_en  = 1'b0;
      flush     = 1'b0;
      chk_addr1 = 5'd0;
      chk_addr2 = 5'd0;
      offer(1'b0, 5'd0, 32'd0, 32'd0);

      // ---------------- Reset ----------------
      step();
      step();
      reset = 1'b1;
      sample();
      check_eq("rst_count",    64'(count),    64'd0);
      check_eq("rst_we",       64'(grf_we),   64'd0);
      check_eq("rst_a3",       64'(grf_a3),   64'd0);
      check_eq("rst_wd",       64'(grf_wd),   64'd0);
      check_eq("rst_wpc",      64'(grf_wpc),  64'd0);
      check_eq("rst_hit1",     64'(chk_hit1), 64'd0);
      check_eq("rst_hit2",     64'(chk_hit2), 64'd0);
      check_eq("rst_in_ready", 64'(in_ready), 64'd1);

      // ---------------- Single write ----------------
      step();
      drain_en = 1'b1;
      offer(1'b1, 5'd5, 32'h1234_5678, 32'h0000_3004);
      sample();
      check_eq("single_ready", 64'(in_ready), 64'd1);
      check_eq("single_we_pre", 64'(grf_we), 64'd0);
      step();
      offer(1'b0, 5'd0, 32'd0, 32'd0);
      sample();
      check_eq("single_we",  64'(grf_we),  64'd1);
      check_eq("single_a3",  64'(grf_a3),  64'd5);
      check_eq("single_wd",  64'(grf_wd),  64'h1234_5678);
      check_eq("single_wpc", 64'(grf_wpc), 64'h3004);
      step();
      sample();
      check_eq("single_count_after", 64'(count),  64'd0);
      check_eq("single_we_after",    64'(grf_we), 64'd0);

      // ---------------- Fill and probe ----------------
      drain_en = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         offer(1'b1, 5'(i), 32'h100 + 32'(i), 32'h3000 + 32'(4 * i));
         step();
      end
      offer(1'b1, 5'd7, 32'hDEAD_BEEF, 32'h0);
      chk_addr1 = 5'd3;
      chk_addr2 = 5'd9;
      sample();
      check_eq("fill_count", 64'(count),    64'd4);
      check_eq("fill_ready", 64'(in_ready), 64'd0);
      check_eq("fill_hit1",  64'(chk_hit1), 64'd1);
      check_eq("fill_hit2",  64'(chk_hit2), 64'd0);
      check_eq("fill_we",    64'(grf_we),   64'd0);
      // Offer held while full must not enter the queue.
      step();
      offer(1'b0, 5'd0, 32'd0, 32'd0);
      drain_en  = 1'b1;
      chk_addr1 = 5'd1;   // head entry, popped this cycle, still counts
      chk_addr2 = 5'd7;   // refused offer, must not appear
      sample();
      check_eq("full_hold_count", 64'(count),    64'd4);
      check_eq("probe_head_pop",  64'(chk_hit1), 64'd1);
      check_eq("probe_refused",   64'(chk_hit2), 64'd0);
      for (int i = 1; i <= 4; i++) begin
         check_eq("drain_we", 64'(grf_we),  64'd1);
         check_eq("drain_a3", 64'(grf_a3),  64'(i));
         check_eq("drain_wd", 64'(grf_wd),  64'h100 + 64'(i));
         check_eq("drain_wpc", 64'(grf_wpc), 64'h3000 + 64'(4 * i));
         step();
         sample();
      end
      check_eq("drain_empty", 64'(count),  64'd0);
      check_eq("drain_we_end", 64'(grf_we), 64'd0);

      // ---------------- $0 discard ----------------
      step();
      offer(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h4000);
      chk_addr1 = 5'd0;
      sample();
      check_eq("zero_ready", 64'(in_ready), 64'd1);
      step();
      offer(1'b0, 5'd0, 32'd0, 32'd0);
      sample();
      check_eq("zero_count", 64'(count),    64'd0);
      check_eq("zero_we",    64'(grf_we),   64'd0);
      check_eq("zero_hit1",  64'(chk_hit1), 64'd0);

      // ---------------- Flush priority ----------------
      drain_en = 1'b0;
      offer(1'b1, 5'd10, 32'hA, 32'h10);
      step();
      offer(1'b1, 5'd11, 32'hB, 32'h14);
      step();
      offer(1'b1, 5'd12, 32'hC, 32'h18);
      flush    = 1'b1;
      drain_en = 1'b1;
      sample();
      check_eq("flush_pre_count", 64'(count),    64'd2);
      check_eq("flush_ready",     64'(in_ready), 64'd0);
      check_eq("flush_we",        64'(grf_we),   64'd0);
      step();
      flush = 1'b0;
      offer(1'b0, 5'd0, 32'd0, 32'd0);
      chk_addr1 = 5'd12;
      sample();
      check_eq("flush_count", 64'(count),    64'd0);
      check_eq("flush_we_1",  64'(grf_we),   64'd0);
      check_eq("flush_hit",   64'(chk_hit1), 64'd0);
      step();
      sample();
      check_eq("flush_we_2",  64'(grf_we),   64'd0);

      // ---------------- Concurrent push/pop across wrap ----------------
      // Three entries fill slots 0..2, leaving the tail at slot 3; six
      // push+pop cycles then carry both pointers across the wrap.
      for (int i = 0; i < 9; i++) exp_addr[i] = 5'(20 + i);
      drain_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         offer(1'b1, exp_addr[i], 32'h5000 + 32'(i), 32'h6000 + 32'(i));
         step();
      end
      drain_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         offer(1'b1, exp_addr[i + 3], 32'h5000 + 32'(i + 3), 32'h6000 + 32'(i + 3));
         sample();
         check_eq("wrap_count", 64'(count),    64'd3);
         check_eq("wrap_ready", 64'(in_ready), 64'd1);
         check_eq("wrap_we",    64'(grf_we),   64'd1);
         check_eq("wrap_a3",    64'(grf_a3),   64'(exp_addr[i]));
         check_eq("wrap_wd",    64'(grf_wd),   64'h5000 + 64'(i));
         step();
      end
      offer(1'b0, 5'd0, 32'd0, 32'd0);
      for (int i = 6; i < 9; i++) begin
         sample();
         check_eq("wrap_tail_a3", 64'(grf_a3), 64'(exp_addr[i]));
         check_eq("wrap_tail_we", 64'(grf_we), 64'd1);
         step();
      end
      sample();
      check_eq("wrap_empty", 64'(count), 64'd0);

      // ---------------- Reset mid-drain ----------------
      drain_en = 1'b0;
      offer(1'b1, 5'd30, 32'h77, 32'h88);
      step();
      offer(1'b1, 5'd31, 32'h99, 32'hAA);
      step();
      offer(1'b0, 5'd0, 32'd0, 32'd0);
      drain_en = 1'b1;
      reset    = 1'b0;
      step();
      reset = 1'b1;
      chk_addr1 = 5'd31;
      sample();
      check_eq("midrst_count", 64'(count),    64'd0);
      check_eq("midrst_we",    64'(grf_we),   64'd0);
      check_eq("midrst_a3",    64'(grf_a3),   64'd0);
      check_eq("midrst_hit",   64'(chk_hit1), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/grf_wb_queue.md
# grf_wb_queue

Write-back queue feeding the general register file (GRF) write port. It accepts register-write requests (address, data, PC) from the write-back stage through a valid/ready handshake and buffers them in an in-order FIFO. It issues at most one GRF write per cycle, and only while `drain_en` allows it. For hazard detection it reports whether a queued write targets either of two probe addresses. It sits between the W stage and the GRF write port (`A3/WD/WE/WPC`).

## Interface

- `DEPTH`, default 4: number of queue entries; power of two, ≥ 2.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; `reset == 0` at a rising edge clears all state.
- `in_valid`  in  1  write request present.
- `in_ready`  out  1  queue can accept a request this cycle.
- `in_addr`  in  5  destination register number.
- `in_data`  in  32  write data.
- `in_pc`  in  32  PC of the producing instruction; passed through unchanged.
- `drain_en`  in  1  GRF write port available this cycle.
- `flush`  in  1  discard all queued and concurrently offered requests.
- `grf_we`  out  1  GRF write enable.
- `grf_a3`  out  5  GRF write address.
- `grf_wd`  out  32  GRF write data.
- `grf_wpc`  out  32  PC reported with the write.
- `chk_addr1`, `chk_addr2`  in  5 each  probe addresses from decode.
- `chk_hit1`, `chk_hit2`  out  1 each  a queued entry targets the probe address.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation

- **Storage:** circular FIFO with head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. Occupancy is held in `count`.
- **Handshake:**
  - `in_ready = (count < DEPTH) && !flush`.
  - A push happens when `in_valid && in_ready`.
  - `in_ready` does not depend on a same-cycle pop.
- **Writes to `$0`:** a request with `in_addr == 0` completes the handshake but is discarded. It is never enqueued and never produces `grf_we`.
- **Pop:** happens when `count != 0 && drain_en && !flush`.
- **Output drive:** `grf_we` equals the pop condition. `grf_a3`, `grf_wd` and `grf_wpc` come from the head entry and are combinational from registered storage. When `count == 0` they are 0.
- **Ordering:** strict FIFO. Multiple entries to the same register are all written, oldest first, with no coalescing.
- **Simultaneous push and pop:** both take effect and `count` is unchanged. When the queue is full, no push occurs even if a pop happens in that cycle.
- **Flush:**
  - The queue empties at the next edge.
  - Any concurrent push is rejected (`in_ready = 0`).
  - `grf_we = 0` in the flush cycle.
- **Probes:**
  - `chk_hitN = 1` iff `chk_addrN != 0` and some occupied entry has `addr == chk_addrN`.
  - Only queued entries are considered: the request currently on `in_*` is not, and the head entry being popped this cycle still counts.
  - Probes are purely combinational.
- **Reset:** resets pointers and `count` and clears storage contents. While `reset == 0`, `flush` has no additional effect.

## Timing

- Reset values, with `reset == 0` at an edge: `count = 0`, `grf_we = 0`, `grf_a3 = 0`, `grf_wd = 0`, `grf_wpc = 0`, `chk_hit1 = chk_hit2 = 0`. `in_ready = 1` from the first cycle after reset, provided `flush == 0`.
- Latency: a request pushed at edge E (empty queue, `drain_en == 1`) drives `grf_we = 1` in the cycle following E. The GRF commits it at edge E+1.
- Throughput: one push and one pop per cycle; sustained at full rate with no bubbles.
- A full queue with `drain_en == 0` holds indefinitely; `in_ready` stays 0.
- A `reset` asserted mid-drain takes effect at that edge. No partial write is issued in that cycle, because the GRF is also in reset.

## Test plan

- **Reset:** hold `reset = 0` for 2 cycles, then release → `count = 0`, `grf_we = 0`, all outputs 0, `in_ready = 1`.
- **Single write:** push (addr 5, data 0x1234_5678, pc 0x3004) with `drain_en = 1` → next cycle `grf_we = 1`, `grf_a3 = 5`, `grf_wd = 0x1234_5678`, `grf_wpc = 0x3004`; the cycle after, `count = 0`.
- **Fill and probe:** `drain_en = 0`, push addrs 1, 2, 3, 4 (DEPTH 4) → `count = 4`, `in_ready = 0`; `chk_addr1 = 3` → `chk_hit1 = 1`, `chk_addr2 = 9` → 0. Then `drain_en = 1` → writes appear for 1, 2, 3, 4 in consecutive cycles.
- **`$0` discard:** push addr 0 with data 0xFFFF_FFFF → handshake completes, `count` stays 0, `grf_we` never asserts; `chk_addr1 = 0` → `chk_hit1 = 0`.
- **Flush priority:** queue holds 2 entries, then assert `flush` together with `in_valid` → `in_ready = 0` and `grf_we = 0` that cycle; next cycle `count = 0` and no writes follow.
- **Concurrent push/pop at wrap:** with 3 entries and the tail at index 3, push and pop together for 6 cycles → `count` stays 3, and the write order matches the push order across the pointer wrap.
